// File: rtl/vga_scanout.sv
// XGA raster generator and grayscale frame-buffer scanout. Counters drive a fetch stage and a
// flag delay line so that sync, colour and frame_start arrive together with the fetched pixels.
module vga_scanout #(
    parameter int          H_ACTIVE    = 1024,
    parameter int          H_FP        = 24,
    parameter int          H_SYNC      = 136,
    parameter int          H_BP        = 160,
    parameter int          V_ACTIVE    = 768,
    parameter int          V_FP        = 3,
    parameter int          V_SYNC      = 6,
    parameter int          V_BP        = 29,
    parameter int          IMG_W       = 512,
    parameter int          IMG_H       = 512,
    parameter int          IMG_X       = 256,
    parameter int          IMG_Y       = 128,
    parameter logic [31:0] IMG_BASE0   = 32'h0000_0000,
    parameter logic [31:0] IMG_BASE1   = 32'h0004_0000,
    parameter int          MEM_LATENCY = 2,
    parameter logic [23:0] BORDER_RGB  = 24'h202020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        image_select,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = MEM_LATENCY + 1;

    typedef struct packed {
        logic       active;
        logic       in_img;
        logic       hs;
        logic       vs;
        logic [1:0] lane;
        logic       origin;
    } flags_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic [HW-1:0] h_off;
    logic [VW-1:0] v_off;
    logic [31:0]   pix_offset;
    logic [31:0]   base;
    logic          fetch;
    flags_t        flags0;
    flags_t        dly [DEPTH];
    flags_t        out_f;
    logic [31:0]   word;
    logic [7:0]    pixel;

    assign h_wrap = (h_cnt == HW'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == VW'(V_TOTAL - 1));

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    assign h_off      = h_cnt - HW'(IMG_X);
    assign v_off      = v_cnt - VW'(IMG_Y);
    assign pix_offset = 32'(v_off) * 32'(IMG_W) + 32'(h_off);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        flags0        = '0;
        flags0.active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        flags0.in_img = (h_cnt >= HW'(IMG_X)) && (h_cnt < HW'(IMG_X + IMG_W)) &&
                        (v_cnt >= VW'(IMG_Y)) && (v_cnt < VW'(IMG_Y + IMG_H));
        flags0.hs     = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                        (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
        flags0.vs     = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                        (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
        flags0.lane   = h_off[1:0];
        flags0.origin = (h_cnt == '0) && (v_cnt == '0);
    end

    assign fetch = flags0.in_img && (flags0.lane == 2'd0);

    // The buffer only changes on the last pixel of a frame, so a frame never mixes buffers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base    <= IMG_BASE0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (h_wrap && v_wrap)
                base <= image_select ? IMG_BASE1 : IMG_BASE0;
            rd_en <= fetch;
            if (fetch)
                rd_addr <= base + pix_offset;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                dly[i] <= '0;
        end else begin
            dly[0] <= flags0;
            for (int i = 1; i < DEPTH; i++)
                dly[i] <= dly[i-1];
        end
    end

    // NOTE: the word register is pure datapath; the reset flags already force blank output,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (dly[MEM_LATENCY-1].in_img && (dly[MEM_LATENCY-1].lane == 2'd0))
            word <= rd_data;
    end

    assign out_f = dly[DEPTH-1];
    assign pixel = word[{out_f.lane, 3'b000} +: 8];

    always_comb begin
        rgb_out = '0;
        if (out_f.in_img)
            rgb_out = {pixel, pixel, pixel};
        else if (out_f.active)
            rgb_out = BORDER_RGB;
    end

    assign hsync       = ~out_f.hs;
    assign vsync       = ~out_f.vs;
    assign frame_start = out_f.origin;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display back end of the interpolation graphics path. It generates XGA (1024x768 at 60 Hz, 65 MHz pixel clock) horizontal and vertical timing and fetches 8-bit grayscale pixels from the frame memory read port. It expands each pixel to 24-bit RGB and presents hsync/vsync/rgb_out pipeline-aligned to the VGA DAC. Two image buffers are selectable, with switching only at frame boundaries, so the interpolator can write one buffer while the other is displayed.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- IMG_W, 512, image width in pixels; multiple of 4
- IMG_H, 512, image height in lines
- IMG_X, 256, image left edge; multiple of 4
- IMG_Y, 128, image top line
- IMG_BASE0, 32'h0000_0000, byte base address of buffer 0
- IMG_BASE1, 32'h0004_0000, byte base address of buffer 1
- MEM_LATENCY, 2, cycles from rd_en to valid rd_data; must be at least 1
- BORDER_RGB, 24'h202020, colour of active area outside the image
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- image_select  in  1  0 = buffer 0, 1 = buffer 1
- rd_en  out  1  frame memory read strobe
- rd_addr  out  32  byte address, word aligned
- rd_data  in  32  four pixels; byte k is pixel at rd_addr+k
- hsync  out  1  active-low
- vsync  out  1  active-low
- rgb_out  out  24  {R,G,B}
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Counters h_cnt 0..H_TOTAL-1 (1343) and v_cnt 0..V_TOTAL-1 (805).
  - h_cnt increments every cycle and wraps to 0.
  - v_cnt increments when h_cnt wraps and wraps to 0 after 805.
- Stage 0 (counter values) is decoded as follows:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - in_img = IMG_X<=h<IMG_X+IMG_W && IMG_Y<=v<IMG_Y+IMG_H.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Fetch: in stage 0, when in_img && (h-IMG_X)[1:0]==0:
  - rd_en=1 (registered, one cycle).
  - rd_addr = base + (v-IMG_Y)*IMG_W + (h-IMG_X), in 32-bit arithmetic.
- Word capture: rd_data is captured into a word register in the cycle it is valid. Lane k=(h-IMG_X)[1:0], delayed, selects byte k as the pixel.
- Pixel colour:
  - Image pixel p gives rgb {p,p,p}.
  - Active but not in_img gives BORDER_RGB.
  - Blanking gives 24'h000000.
- Buffer select: base is latched from image_select only on the cycle where h_cnt==1343 && v_cnt==805. A change mid-frame takes effect at the next frame's (0,0).
- No state machine beyond the counters. All control flags travel through a delay line of MEM_LATENCY+1 registers so they stay aligned with the data. The flags are active, in_img, hs, vs, lane and frame-origin.

## Timing
- Reset (reset=0), asynchronous:
  - h_cnt=0, v_cnt=0.
  - All delay stages cleared to blank, with hs=vs=0.
  - hsync=1, vsync=1, rgb_out=0, rd_en=0, rd_addr=0, frame_start=0.
  - base=IMG_BASE0.
- Counting starts on the first rising edge after reset deasserts. Pixel (0,0) appears at the outputs MEM_LATENCY+1 cycles later; that is cycle 3 with default parameters.
- Total latency from counter to outputs is MEM_LATENCY+1. hsync, vsync, rgb_out and frame_start change on the same edge.
- rd_en is registered, so the memory is addressed one cycle after stage 0. rd_data is sampled MEM_LATENCY cycles after rd_en.
- Reads occur at 1 in 4 cycles within the image; there are no reads outside it.
- Reset asserted mid-line or mid-frame:
  - Outputs go to reset values immediately.
  - No partial frame is resumed; the next frame starts at (0,0).
- image_select changing in the same cycle as the latch point: the new value is taken.

## Test plan
- Reset: hold reset=0 for 5 cycles. Required: hsync=vsync=1, rgb_out=0, rd_en=0. Release; frame_start pulses exactly once, 3 cycles later.
- Line/frame timing:
  - hsync period 1344 cycles, low for 136 cycles, first falling edge 1048+3 cycles after release.
  - vsync period 1,083,264 cycles, low for 8064 cycles.
- Fetch addressing: the first rd_en of a frame carries rd_addr=32'h0. The rd_en for line v=129, h=260 carries rd_addr=32'h204. Exactly 128 reads per image line and 65,536 per frame.
- Pixel mapping: a memory model returns a word whose byte k = (addr+k)[7:0].
  - At image pixel (260,128), rgb_out=24'h040404.
  - At (255,128), rgb_out=24'h202020.
  - In blanking, rgb_out=0.
- Buffer switch: set image_select=1 mid-frame. The rest of the frame reads from base 0; the first read of the next frame is rd_addr=32'h0004_0000.
- Mid-frame reset at v=400, h=700. Outputs return to reset values asynchronously, and after release the timing restarts exactly as in the first test.
